// File: rtl/riscv_pkg.sv
// Shared constants and types for the instruction fetch stage.
package riscv_pkg;

  localparam int unsigned XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } fetch_state_e;

  function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory request/response channel between fetch (master) and memory (slave).
interface fetch_unit_if;
  import riscv_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data
  );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO buffering returned instructions; clear has priority over push/pop.
module fetch_fifo #(
  parameter  int unsigned DEPTH = 2,
  parameter  int unsigned WIDTH = 32,
  localparam int unsigned CW    = $clog2(DEPTH + 1),
  localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_q, wr_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (clear_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= next_ptr(wr_q);
      if (do_pop)  rd_q <= next_ptr(rd_q);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear_i) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC generation, credit-limited imem requests, response buffer and IF/ID register.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int unsigned     FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  fetch_unit_if.master    imem,
  input  logic            StallD,
  input  logic            FlushD,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic [31:0]     InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            InstrValidD,
  output logic            FetchFaultD
);

  localparam int unsigned CW  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned CWP = CW + 1;
  localparam logic [1:0] ST_FETCH = FETCH;
  localparam logic [1:0] ST_DRAIN = DRAIN;
  localparam logic [1:0] ST_HALT  = HALT;

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, deliver_pc_q, deliver_pc_d;
  logic [CW-1:0]   out_cnt_q, out_cnt_d, drop_cnt_q, drop_cnt_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] pcd_q, pcd_d;
  logic            valid_q, valid_d;

  logic [XLEN-1:0] target;
  logic            misalign;
  logic [CW-1:0]   fifo_cnt;
  logic [31:0]     fifo_head;
  logic            fifo_full, fifo_empty, fifo_pop, rsp_push;
  logic            req_valid, req_hs, rsp_v;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign target   = PCTargetE;
  assign misalign = |PCTargetE[1:0];
`else
  logic unused_tgt_lsb;
  assign unused_tgt_lsb = ^PCTargetE[1:0];
  assign target   = {PCTargetE[XLEN-1:2], 2'b00};
  assign misalign = 1'b0;
`endif

  // Stale requests still hold credits, so the limit covers every request that can still respond.
  assign req_valid = !reset && !PCSrcE && (state_q != ST_HALT) &&
                     (({1'b0, out_cnt_q} + {1'b0, fifo_cnt}) < CWP'(FIFO_DEPTH));
  assign req_hs    = req_valid && imem.imem_req_ready;
  assign rsp_v     = imem.imem_rsp_valid;
  assign rsp_push  = rsp_v && (drop_cnt_q == '0) && !PCSrcE;
  assign fifo_pop  = !PCSrcE && !FlushD && !StallD && !fifo_empty;

  assign imem.imem_req_valid = req_valid;
  assign imem.imem_req_addr  = fetch_pc_q;

  fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .push_i  (rsp_push),
    .pop_i   (fifo_pop),
    .clear_i (PCSrcE),
    .data_i  (imem.imem_rsp_data),
    .data_o  (fifo_head),
    .count_o (fifo_cnt),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    out_cnt_d    = out_cnt_q + CW'(req_hs) - CW'(rsp_v);
    drop_cnt_d   = drop_cnt_q;
    fetch_pc_d   = fetch_pc_q;
    deliver_pc_d = deliver_pc_q;
    state_d      = state_q;
    instr_d      = instr_q;
    pcd_d        = pcd_q;
    valid_d      = valid_q;
    if (PCSrcE) begin
      // Everything still outstanding after this edge belongs to the old stream.
      drop_cnt_d   = out_cnt_d;
      fetch_pc_d   = target;
      deliver_pc_d = target;
      instr_d      = NOP_INSTR;
      valid_d      = 1'b0;
      if (misalign)               state_d = ST_HALT;
      else if (out_cnt_d != '0)   state_d = ST_DRAIN;
      else                        state_d = ST_FETCH;
    end else begin
      if (req_hs) fetch_pc_d = pc_plus4(fetch_pc_q);
      if (rsp_v && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CW'(1);
      if (FlushD) begin
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
      end else if (!StallD) begin
        if (!fifo_empty) begin
          instr_d      = fifo_head;
          pcd_d        = deliver_pc_q;
          valid_d      = 1'b1;
          deliver_pc_d = pc_plus4(deliver_pc_q);
        end else begin
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
        end
      end
      if ((state_q == ST_DRAIN) && (drop_cnt_d == '0)) state_d = ST_FETCH;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_FETCH;
      fetch_pc_q   <= RESET_PC;
      deliver_pc_q <= RESET_PC;
      out_cnt_q    <= '0;
      drop_cnt_q   <= '0;
      instr_q      <= NOP_INSTR;
      pcd_q        <= RESET_PC;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      deliver_pc_q <= deliver_pc_d;
      out_cnt_q    <= out_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      instr_q      <= instr_d;
      pcd_q        <= pcd_d;
      valid_q      <= valid_d;
    end
  end

  assign InstrD      = instr_q;
  assign PCD         = pcd_q;
  assign PCPlus4D    = pc_plus4(pcd_q);
  assign InstrValidD = valid_q;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign FetchFaultD = (state_q == ST_HALT);
`else
  assign FetchFaultD = 1'b0;
`endif

  a_rsp_has_slot: assert property (@(posedge clk) disable iff (reset) !(rsp_push && fifo_full));

endmodule
